matrix_rd_seq: RTL and testbench

//  Read sequencer for the matrix data RAM wrapper (2-cycle BRAM + 2-entry shift read buffer).

---
 rtl/matrix_rd_seq.sv | 212 +++++++++++++++++++++
 tb/tb_matrix_rd_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_rd_seq.sv
// matrix_rd_seq: read sequencer for the matrix data RAM wrapper. The wrapper has a
// 2-cycle BRAM and a 2-entry shift read buffer. This block walks an R x C row-major
// matrix from a base address, in row-major or column-major (transpose) order. It
// returns the elements as a valid/ready stream and hides the BRAM latency, so it
// delivers 1 element/cycle while m_ready=1 and drops nothing under backpressure.
//
// Ports:
//   clka, rsta               clock, asynchronous active-high reset
//   start                    job start pulse (ignored while busy)
//   base_addr, rows, cols    element (0,0) address, R, C (C is also row pitch)
//   col_major                0: row-major walk, 1: column-major walk
//   busy, done               job in progress / 1-cycle completion pulse
//   ram_addr, ram_rd         RAM word address and read-issue strobe
//   ram_shift, ram_out_sel   read buffer control (00 buf0, 01 buf1, 10 bypass)
//   ram_dout                 RAM wrapper read data
//   m_data, m_valid, m_ready, m_last   output element stream
module matrix_rd_seq #(
  parameter int ADDR_MSB = 11,
  parameter int DIM_W    = 7
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                start,
  input  logic [ADDR_MSB:0]   base_addr,
  input  logic [DIM_W-1:0]    rows,
  input  logic [DIM_W-1:0]    cols,
  input  logic                col_major,
  output logic                busy,
  output logic                done,
  output logic [ADDR_MSB:0]   ram_addr,
  output logic                ram_rd,
  output logic                ram_shift,
  output logic [1:0]          ram_out_sel,
  input  logic [31:0]         ram_dout,
  output logic [31:0]         m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int AW = ADDR_MSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_MSB:0] addr;
  logic [ADDR_MSB:0] col_start;
  logic [DIM_W-1:0]  rows_r;
  logic [DIM_W-1:0]  cols_r;
  logic [DIM_W-1:0]  row_idx;
  logic [DIM_W-1:0]  col_idx;
  logic              col_major_r;

  // p1/p2: reads issued one and two cycles ago, each with its last tag
  logic              p1;
  logic              p1_last;
  logic              p2;
  logic              p2_last;

  // Elements held in the wrapper buffer, plus the last tags that shadow buf[0]/buf[1]
  logic [1:0]        cnt;
  logic              buf0_last;
  logic              buf1_last;

  logic              empty;
  logic              pop;
  logic              issue;
  logic              issue_last;
  logic              row_end;
  logic              col_end;
  logic [2:0]        occ;
  logic [1:0]        cnt_next;
  logic [ADDR_MSB:0] addr_next;

  always_comb begin
    empty   = (cnt == 2'd0);
    m_valid = !empty || p2;
    pop     = m_valid && m_ready;

    // The oldest element is buf[0] when the buffer is full, buf[1] when it holds one
    // element, and the RAM output itself when the buffer is empty.
    ram_out_sel = 2'b10;
    m_last      = p2 && p2_last;
    case (cnt)
      2'd2: begin
        ram_out_sel = 2'b00;
        m_last      = buf0_last;
      end
      2'd1: begin
        ram_out_sel = 2'b01;
        m_last      = buf1_last;
      end
      default: begin
        ram_out_sel = 2'b10;
        m_last      = p2 && p2_last;
      end
    endcase

    // Arriving data is captured unless it is consumed straight from the bypass path
    ram_shift = p2 && !(empty && pop);
    cnt_next  = cnt + {1'b0, ram_shift} - {1'b0, pop && !empty};

    // Count everything already owed to the buffer so that it can never overflow
    occ   = {1'b0, cnt} + {2'b00, p1} + {2'b00, p2};
    issue = (state == RUN) && (occ < (3'd2 + {2'b00, pop}));

    row_end    = (row_idx == rows_r - DIM_W'(1));
    col_end    = (col_idx == cols_r - DIM_W'(1));
    issue_last = row_end && col_end;

    if (col_major_r) begin
      addr_next = row_end ? (col_start + AW'(1)) : (addr + AW'(cols_r));
    end else begin
      addr_next = addr + AW'(1);
    end

    ram_rd   = issue;
    ram_addr = addr;
    m_data   = ram_dout;
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state       <= IDLE;
      addr        <= '0;
      col_start   <= '0;
      rows_r      <= '0;
      cols_r      <= '0;
      row_idx     <= '0;
      col_idx     <= '0;
      col_major_r <= 1'b0;
      p1          <= 1'b0;
      p1_last     <= 1'b0;
      p2          <= 1'b0;
      p2_last     <= 1'b0;
      cnt         <= '0;
      buf0_last   <= 1'b0;
      buf1_last   <= 1'b0;
    end else begin
      p1      <= issue;
      p1_last <= issue && issue_last;
      p2      <= p1;
      p2_last <= p1_last;
      cnt     <= cnt_next;
      if (ram_shift) begin
        buf0_last <= buf1_last;
        buf1_last <= p2_last;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            if ((rows == '0) || (cols == '0)) begin
              state <= DONE;
            end else begin
              state       <= RUN;
              addr        <= base_addr;
              col_start   <= base_addr;
              rows_r      <= rows;
              cols_r      <= cols;
              col_major_r <= col_major;
              row_idx     <= '0;
              col_idx     <= '0;
            end
          end
        end
        RUN: begin
          if (issue) begin
            // The final address is not advanced past, so ram_addr holds it.
            if (issue_last) begin
              state <= DRAIN;
            end else begin
              addr <= addr_next;
              if (col_major_r) begin
                if (row_end) begin
                  row_idx   <= '0;
                  col_idx   <= col_idx + DIM_W'(1);
                  col_start <= col_start + AW'(1);
                end else begin
                  row_idx <= row_idx + DIM_W'(1);
                end
              end else begin
                if (col_end) begin
                  col_idx <= '0;
                  row_idx <= row_idx + DIM_W'(1);
                end else begin
                  col_idx <= col_idx + DIM_W'(1);
                end
              end
            end
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_rd_seq.sv
// Directed testbench for matrix_rd_seq. It contains a behavioural RAM wrapper
// (2-cycle read plus a 2-entry shift buffer with out_sel mux) and checks the addresses,
// the stream contents and order, the last flags and the job timing.
module tb_matrix_rd_seq;

  localparam int ADDR_MSB = 11;
  localparam int DIM_W    = 7;

  logic                clka = 1'b0;
  logic                rsta;
  logic                start;
  logic [ADDR_MSB:0]   base_addr;
  logic [DIM_W-1:0]    rows;
  logic [DIM_W-1:0]    cols;
  logic                col_major;
  logic                busy;
  logic                done;
  logic [ADDR_MSB:0]   ram_addr;
  logic                ram_rd;
  logic                ram_shift;
  logic [1:0]          ram_out_sel;
  logic [31:0]         ram_dout;
  logic [31:0]         m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  int checks   = 0;
  int failures = 0;

  matrix_rd_seq #(
    .ADDR_MSB(ADDR_MSB),
    .DIM_W   (DIM_W)
  ) dut (
    .clka       (clka),
    .rsta       (rsta),
    .start      (start),
    .base_addr  (base_addr),
    .rows       (rows),
    .cols       (cols),
    .col_major  (col_major),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_shift  (ram_shift),
    .ram_out_sel(ram_out_sel),
    .ram_dout   (ram_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  always #5 clka = ~clka;

  function automatic logic [31:0] mem_word(input logic [ADDR_MSB:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  // RAM wrapper model
  logic [31:0] rd_s1 = '0;
  logic [31:0] rd_s2 = '0;
  logic [31:0] rb0   = '0;
  logic [31:0] rb1   = '0;

  always @(posedge clka) begin
    rd_s1 <= mem_word(ram_addr);
    rd_s2 <= rd_s1;
    if (ram_shift) begin
      rb0 <= rb1;
      rb1 <= rd_s2;
    end
  end

  always_comb begin
    case (ram_out_sel)
      2'b00:   ram_dout = rb0;
      2'b01:   ram_dout = rb1;
      default: ram_dout = rd_s2;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-job record
  logic [ADDR_MSB:0] exp_addr[$];
  logic [ADDR_MSB:0] rd_q[$];
  logic [31:0]       data_q[$];
  logic              last_q[$];
  logic [1:0]        sel_log[0:31];
  int cyc, first_rd, last_rd, first_val, last_beat, done_cyc, idle_cyc, stall_rd;
  int stall_lo, stall_hi;

  task automatic sample();
    if (ram_rd) begin
      rd_q.push_back(ram_addr);
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (cyc >= stall_lo && cyc <= stall_hi) stall_rd++;
    end
    if (m_valid && first_val < 0) first_val = cyc;
    if (m_valid && m_ready) begin
      data_q.push_back(m_data);
      last_q.push_back(m_last);
      if (m_last) last_beat = cyc;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    if (cyc > 0 && !busy && idle_cyc < 0) idle_cyc = cyc;
    if (cyc < 32) sel_log[cyc] = ram_out_sel;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, ".busy"},    {31'b0, busy},        32'd0);
    check({pfx, ".done"},    {31'b0, done},        32'd0);
    check({pfx, ".ram_rd"},  {31'b0, ram_rd},      32'd0);
    check({pfx, ".shift"},   {31'b0, ram_shift},   32'd0);
    check({pfx, ".addr"},    {20'b0, ram_addr},    32'd0);
    check({pfx, ".out_sel"}, {30'b0, ram_out_sel}, 32'd2);
    check({pfx, ".m_valid"}, {31'b0, m_valid},     32'd0);
    check({pfx, ".m_last"},  {31'b0, m_last},      32'd0);
  endtask

  // Runs one job from a start in cycle 0; m_ready is low in cycles lo..hi, and a
  // conflicting start is pulsed in cycle restart_at to check it is ignored.
  task automatic run_job(input string name, input logic [ADDR_MSB:0] b, input int r,
                         input int c, input logic cm, input int lo, input int hi,
                         input int restart_at);
    @(posedge clka);
    #1;
    rd_q.delete();
    data_q.delete();
    last_q.delete();
    first_rd = -1; last_rd = -1; first_val = -1; last_beat = -1;
    done_cyc = -1; idle_cyc = -1; stall_rd = 0;
    stall_lo = lo; stall_hi = hi;
    cyc = 0;
    base_addr = b;
    rows      = DIM_W'(r);
    cols      = DIM_W'(c);
    col_major = cm;
    start     = 1'b1;
    m_ready   = !(cyc >= lo && cyc <= hi);
    #1;
    sample();
    while (cyc < 200) begin
      @(posedge clka);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == restart_at) begin
        start     = 1'b1;
        base_addr = 12'h300;
        rows      = 7'd2;
        cols      = 7'd2;
        col_major = ~cm;
      end
      m_ready = !(cyc >= lo && cyc <= hi);
      #1;
      sample();
      if (!busy) break;
    end
    start = 1'b0;
    check({name, ".timeout"}, {31'b0, busy}, 32'd0);
    check({name, ".n_rd"},    rd_q.size(),   exp_addr.size());
    check({name, ".n_beats"}, data_q.size(), exp_addr.size());
    foreach (exp_addr[i]) begin
      if (i < rd_q.size())
        check($sformatf("%s.addr%0d", name, i), {20'b0, rd_q[i]}, {20'b0, exp_addr[i]});
      if (i < data_q.size()) begin
        check($sformatf("%s.data%0d", name, i), data_q[i], mem_word(exp_addr[i]));
        check($sformatf("%s.last%0d", name, i), {31'b0, last_q[i]},
              {31'b0, (i == exp_addr.size() - 1)});
      end
    end
  endtask

  initial begin
    rsta = 1'b1; start = 1'b0; base_addr = '0; rows = '0; cols = '0;
    col_major = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    check_reset_outputs("rst_init");
    rsta = 1'b0;

    // 1: row-major 2x3 at 0x100, with an ignored start mid-job
    exp_addr = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105};
    run_job("rowmaj", 12'h100, 2, 3, 1'b0, 1000, 0, 4);
    check("rowmaj.first_rd",  first_rd,  1);
    check("rowmaj.last_rd",   last_rd,   6);
    check("rowmaj.first_val", first_val, 3);
    check("rowmaj.last_beat", last_beat, 8);
    check("rowmaj.done",      done_cyc,  9);
    check("rowmaj.idle",      idle_cyc,  10);

    // 2: column-major walk of the same matrix
    exp_addr = '{12'h100, 12'h103, 12'h101, 12'h104, 12'h102, 12'h105};
    run_job("colmaj", 12'h100, 2, 3, 1'b1, 1000, 0, -1);
    check("colmaj.first_val", first_val, 3);
    check("colmaj.last_beat", last_beat, 8);
    check("colmaj.done",      done_cyc,  9);

    // 3: backpressure in cycles 4..7
    exp_addr = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105};
    run_job("stall", 12'h100, 2, 3, 1'b0, 4, 7, -1);
    check("stall.rd_in_stall", stall_rd, 0);
    check("stall.sel4", {30'b0, sel_log[4]}, 32'd2);
    check("stall.sel5", {30'b0, sel_log[5]}, 32'd1);
    check("stall.sel6", {30'b0, sel_log[6]}, 32'd0);
    check("stall.last_beat", last_beat, 12);
    check("stall.done",      done_cyc,  13);

    // 4: empty job, start while busy (DONE) ignored
    exp_addr.delete();
    run_job("empty", 12'h040, 0, 5, 1'b0, 1000, 0, 1);
    check("empty.done",      done_cyc,  1);
    check("empty.idle",      idle_cyc,  2);
    check("empty.first_val", first_val, -1);
    check("empty.first_rd",  first_rd,  -1);

    // 5: address wrap at the top of the RAM
    exp_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    run_job("wrap", 12'hFFE, 1, 4, 1'b0, 1000, 0, -1);
    check("wrap.last_rd",   last_rd,   4);
    check("wrap.last_beat", last_beat, 6);
    check("wrap.done",      done_cyc,  7);

    // 6: reset in cycle 5 of a job, then a clean rerun
    @(posedge clka);
    #1;
    base_addr = 12'h100; rows = 7'd2; cols = 7'd3; col_major = 1'b0;
    m_ready = 1'b1; start = 1'b1;
    @(posedge clka);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clka);
    #1;
    check("rst_mid.busy_before", {31'b0, busy}, 32'd1);
    rsta = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clka);
    #1;
    rsta = 1'b0;
    exp_addr = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105};
    run_job("rerun", 12'h100, 2, 3, 1'b0, 1000, 0, -1);
    check("rerun.first_rd",  first_rd,  1);
    check("rerun.first_val", first_val, 3);
    check("rerun.done",      done_cyc,  9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
